// File: rtl/beat_anim_scheduler.sv
// Beat-driven attack/hold/release envelope for the zoom and blur filter settings.
// Latency: outputs, state and cfg_update are updated one clock after a frame_start step.
// No backpressure: the filter chain samples zoom_value/blur_radius on cfg_update.
module beat_anim_scheduler #(
  parameter int ATTACK_FRAMES  = 4,
  parameter int HOLD_FRAMES    = 2,
  parameter int RELEASE_FRAMES = 8,
  parameter int ZOOM_MIN       = 1,
  parameter int ZOOM_MAX       = 3,
  parameter int BLUR_MIN       = 1,
  parameter int BLUR_MAX       = 4,
  parameter int VAL_W          = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             beat_trigger,
  input  logic             frame_start,
  output logic [VAL_W-1:0] zoom_value,
  output logic [VAL_W-1:0] blur_radius,
  output logic             cfg_update,
  output logic             anim_active,
  output logic             beat_dropped
);

  // Interpolation intermediates: span (VAL_W bits) times frame index (8 bits), plus headroom.
  localparam int IW = VAL_W + 9;

  localparam logic [7:0]       ATK_N = 8'(ATTACK_FRAMES);
  localparam logic [7:0]       HLD_N = 8'(HOLD_FRAMES);
  localparam logic [7:0]       REL_N = 8'(RELEASE_FRAMES);
  localparam logic [VAL_W-1:0] ZMIN  = VAL_W'(ZOOM_MIN);
  localparam logic [VAL_W-1:0] ZMAX  = VAL_W'(ZOOM_MAX);
  localparam logic [VAL_W-1:0] BMIN  = VAL_W'(BLUR_MIN);
  localparam logic [VAL_W-1:0] BMAX  = VAL_W'(BLUR_MAX);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_ATTACK  = 2'd1,
    S_HOLD    = 2'd2,
    S_RELEASE = 2'd3
  } state_t;

  state_t           state, state_n;
  logic [7:0]       cnt, cnt_n;
  logic             pending;
  logic             p;
  logic             drop_step;
  logic [VAL_W-1:0] zoom_n, blur_n;

  // MIN + floor(D*k / ATTACK_FRAMES)
  function automatic logic [VAL_W-1:0] ramp_up(input logic [VAL_W-1:0] mn,
                                               input logic [VAL_W-1:0] mx,
                                               input logic [7:0]       k);
    logic [IW-1:0] d;
    logic [IW-1:0] q;
    d = IW'(mx) - IW'(mn);
    q = (d * IW'(k)) / IW'(ATTACK_FRAMES);
    return mn + VAL_W'(q);
  endfunction

  // MAX - floor(D*k / RELEASE_FRAMES)
  function automatic logic [VAL_W-1:0] ramp_down(input logic [VAL_W-1:0] mn,
                                                 input logic [VAL_W-1:0] mx,
                                                 input logic [7:0]       k);
    logic [IW-1:0] d;
    logic [IW-1:0] q;
    d = IW'(mx) - IW'(mn);
    q = (d * IW'(k)) / IW'(RELEASE_FRAMES);
    return mx - VAL_W'(q);
  endfunction

  // A beat arriving together with the step is consumed by that step.
  assign p           = pending | beat_trigger;
  assign anim_active = (state != S_IDLE);

  // Next-state and next-output decode; nothing moves unless a step occurs.
  always_comb begin
    state_n   = state;
    cnt_n     = cnt;
    zoom_n    = zoom_value;
    blur_n    = blur_radius;
    drop_step = 1'b0;
    if (frame_start) begin
      case (state)
        S_IDLE: begin
          if (p) begin
            state_n = S_ATTACK;
            cnt_n   = 8'd1;
            zoom_n  = ramp_up(ZMIN, ZMAX, 8'd1);
            blur_n  = ramp_up(BMIN, BMAX, 8'd1);
          end else begin
            cnt_n  = 8'd0;
            zoom_n = ZMIN;
            blur_n = BMIN;
          end
        end
        S_ATTACK: begin
          // The attack ramp is never interrupted; a beat here is thrown away.
          drop_step = p;
          if (cnt < ATK_N) begin
            cnt_n  = cnt + 8'd1;
            zoom_n = ramp_up(ZMIN, ZMAX, cnt + 8'd1);
            blur_n = ramp_up(BMIN, BMAX, cnt + 8'd1);
          end else begin
            state_n = S_HOLD;
            cnt_n   = 8'd1;
            zoom_n  = ZMAX;
            blur_n  = BMAX;
          end
        end
        S_HOLD: begin
          zoom_n = ZMAX;
          blur_n = BMAX;
          if (p) begin
            cnt_n = 8'd1;
          end else if (cnt < HLD_N) begin
            cnt_n = cnt + 8'd1;
          end else begin
            state_n = S_RELEASE;
            cnt_n   = 8'd1;
            zoom_n  = ramp_down(ZMIN, ZMAX, 8'd1);
            blur_n  = ramp_down(BMIN, BMAX, 8'd1);
          end
        end
        S_RELEASE: begin
          if (p) begin
            // Retrigger jumps straight back to full strength.
            state_n = S_HOLD;
            cnt_n   = 8'd1;
            zoom_n  = ZMAX;
            blur_n  = BMAX;
          end else if (cnt < REL_N) begin
            cnt_n  = cnt + 8'd1;
            zoom_n = ramp_down(ZMIN, ZMAX, cnt + 8'd1);
            blur_n = ramp_down(BMIN, BMAX, cnt + 8'd1);
          end else begin
            state_n = S_IDLE;
            cnt_n   = 8'd0;
            zoom_n  = ZMIN;
            blur_n  = BMIN;
          end
        end
        default: begin
          state_n = S_IDLE;
          cnt_n   = 8'd0;
          zoom_n  = ZMIN;
          blur_n  = BMIN;
        end
      endcase
    end
  end

  // State, output registers, beat capture and drop reporting.
  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= S_IDLE;
      cnt          <= 8'd0;
      pending      <= 1'b0;
      zoom_value   <= ZMIN;
      blur_radius  <= BMIN;
      cfg_update   <= 1'b0;
      beat_dropped <= 1'b0;
    end else begin
      state        <= state_n;
      cnt          <= cnt_n;
      zoom_value   <= zoom_n;
      blur_radius  <= blur_n;
      cfg_update   <= frame_start;
      pending      <= frame_start ? 1'b0 : p;
      // Second beat in one frame overflows the single-entry pending flag.
      beat_dropped <= drop_step | (beat_trigger & pending & ~frame_start);
    end
  end

endmodule

// File: tb/tb_beat_anim_scheduler.sv
// Scoreboard bench for beat_anim_scheduler using default parameters.
// Each step pushes the expected outputs; the monitor pops them on cfg_update.
// Between steps the outputs must hold the last expected values.
module tb_beat_anim_scheduler;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       beat_trigger = 1'b0;
  logic       frame_start = 1'b0;
  logic [3:0] zoom_value;
  logic [3:0] blur_radius;
  logic       cfg_update;
  logic       anim_active;
  logic       beat_dropped;

  typedef struct {
    int z;
    int b;
    int act;
    int drop;
  } exp_t;

  exp_t sb[$];
  int   n_tests    = 0;
  int   n_fail     = 0;
  int   drops_seen = 0;
  int   last_z     = 1;
  int   last_b     = 1;

  // Full envelope after one beat, steps 1..14.
  int env_z[14] = '{1, 2, 2, 3, 3, 3, 3, 3, 3, 2, 2, 2, 2, 1};
  int env_b[14] = '{1, 2, 3, 4, 4, 4, 4, 4, 3, 3, 3, 2, 2, 1};
  // After a same-cycle start: a(2)..a(4), hold x2, r(1)..r(4).
  int pre_z[9]  = '{2, 2, 3, 3, 3, 3, 3, 3, 2};
  int pre_b[9]  = '{2, 3, 4, 4, 4, 4, 4, 3, 3};
  // After the retrigger: hold cnt 2, then r(1)..r(8).
  int post_z[9] = '{3, 3, 3, 3, 2, 2, 2, 2, 1};
  int post_b[9] = '{4, 4, 4, 3, 3, 3, 2, 2, 1};

  beat_anim_scheduler dut (
    .clk          (clk),
    .reset        (reset),
    .beat_trigger (beat_trigger),
    .frame_start  (frame_start),
    .zoom_value   (zoom_value),
    .blur_radius  (blur_radius),
    .cfg_update   (cfg_update),
    .anim_active  (anim_active),
    .beat_dropped (beat_dropped)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    n_tests++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // One input cycle: inputs change just after a rising edge and are sampled at the next.
  task automatic drive(input logic beat, input logic fs);
    @(posedge clk);
    #1;
    beat_trigger = beat;
    frame_start  = fs;
  endtask

  task automatic step(input logic beat, input int z, input int b, input int act, input int drop);
    sb.push_back('{z, b, act, drop});
    drive(beat, 1'b1);
    drive(1'b0, 1'b0);
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    reset        = 1'b1;
    beat_trigger = 1'b0;
    frame_start  = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    check("rst_zoom", zoom_value, 1);
    check("rst_blur", blur_radius, 1);
    check("rst_cfg", cfg_update, 0);
    check("rst_active", anim_active, 0);
    check("rst_drop", beat_dropped, 0);
  endtask

  // Monitor: score each cfg_update against the queue, otherwise check stability.
  always @(negedge clk) begin : mon
    exp_t e;
    if (reset) begin
      last_z = 1;
      last_b = 1;
    end else begin
      if (beat_dropped) drops_seen++;
      if (cfg_update) begin
        if (sb.size() == 0) begin
          check("unexpected_cfg", 1, 0);
        end else begin
          e = sb.pop_front();
          check("zoom", zoom_value, e.z);
          check("blur", blur_radius, e.b);
          check("active", anim_active, e.act);
          check("drop_on_step", beat_dropped, e.drop);
          last_z = e.z;
          last_b = e.b;
        end
      end else begin
        check("zoom_hold", zoom_value, last_z);
        check("blur_hold", blur_radius, last_b);
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    check("init_zoom", zoom_value, 1);
    check("init_blur", blur_radius, 1);
    check("init_cfg", cfg_update, 0);
    check("init_active", anim_active, 0);
    check("init_drop", beat_dropped, 0);

    // Steps without beats stay idle at MIN.
    for (int i = 0; i < 3; i++) step(1'b0, 1, 1, 0, 0);

    // One beat, then a full un-retriggered envelope.
    drive(1'b1, 1'b0);
    drive(1'b0, 1'b0);
    for (int i = 0; i < 14; i++) step(1'b0, env_z[i], env_b[i], 1, 0);
    step(1'b0, 1, 1, 0, 0);
    repeat (2) drive(1'b0, 1'b0);
    check("drops_env", drops_seen, 0);

    // Beat and step together from IDLE, then retrigger during RELEASE at r(4).
    step(1'b1, 1, 1, 1, 0);
    for (int i = 0; i < 9; i++) step(1'b0, pre_z[i], pre_b[i], 1, 0);
    step(1'b1, 3, 4, 1, 0);
    for (int i = 0; i < 9; i++) step(1'b0, post_z[i], post_b[i], 1, 0);
    step(1'b0, 1, 1, 0, 0);
    repeat (2) drive(1'b0, 1'b0);
    check("drops_retrig", drops_seen, 0);

    // Two beats in one frame, then a beat during ATTACK.
    drops_seen = 0;
    drive(1'b1, 1'b0);
    drive(1'b1, 1'b0);
    drive(1'b0, 1'b0);
    drive(1'b0, 1'b0);
    check("drops_overflow", drops_seen, 1);
    step(1'b0, 1, 1, 1, 0);
    step(1'b1, 2, 2, 1, 1);
    step(1'b0, 2, 3, 1, 0);
    step(1'b0, 3, 4, 1, 0);
    step(1'b0, 3, 4, 1, 0);
    repeat (2) drive(1'b0, 1'b0);
    check("drops_total", drops_seen, 2);

    // Reset while in HOLD with a beat pending; nothing may survive it.
    drive(1'b1, 1'b0);
    do_reset();
    step(1'b0, 1, 1, 0, 0);
    repeat (3) drive(1'b0, 1'b0);

    check("sb_empty", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
